// File: rtl/uart_frame_parser.sv
// Hunts for HEADER0/HEADER1-delimited frames in a UART byte stream, checks LEN and
// the additive checksum, then replays the buffered payload on a valid/ready stream.
module uart_frame_parser #(
    parameter logic [7:0] HEADER0 = 8'h55,
    parameter logic [7:0] HEADER1 = 8'hAA,
    parameter int          MAX_LEN = 32
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic       frame_idle,
    output logic [7:0] out_data,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       out_last,
    output logic [7:0] frame_len,
    output logic       frame_ok,
    output logic       err_pulse,
    output logic [1:0] err_code,
    output logic [7:0] err_cnt
);
    localparam int         AW        = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);

    typedef enum logic [2:0] {
        S_HDR0,
        S_HDR1,
        S_LEN,
        S_PAY,
        S_CSUM,
        S_OUT
    } state_t;

    state_t     state;
    logic [7:0] len;
    logic [7:0] sum;
    logic [7:0] wr_ptr;
    logic [7:0] rd_ptr;
    logic [7:0] mem [0:MAX_LEN-1];

    logic          xfer;
    logic          timeout;
    logic          pay_wr;
    logic          out_take;
    logic [7:0]    len_m1;
    logic [7:0]    rd_next;
    logic [AW-1:0] wr_addr;
    logic [AW-1:0] rd_addr;
    logic          err_now;
    logic [1:0]    err_val;

    assign xfer     = in_valid && in_ready;
    assign timeout  = frame_idle && (state == S_HDR1 || state == S_LEN ||
                                     state == S_PAY  || state == S_CSUM);
    assign pay_wr   = xfer && !timeout && (state == S_PAY);
    assign out_take = out_valid && out_ready;
    assign len_m1   = len - 8'd1;
    assign rd_next  = rd_ptr + 8'd1;
    assign wr_addr  = wr_ptr[AW-1:0];
    assign rd_addr  = rd_next[AW-1:0];

    // Timeout outranks any byte arriving in the same cycle; that byte is simply dropped.
    always_comb begin
        err_now = 1'b0;
        err_val = 2'd0;
        if (timeout) begin
            err_now = 1'b1;
            err_val = 2'd3;
        end else if (xfer && state == S_LEN && (in_data == 8'd0 || in_data > MAX_LEN_B)) begin
            err_now = 1'b1;
            err_val = 2'd1;
        end else if (xfer && state == S_CSUM && in_data != sum) begin
            err_now = 1'b1;
            err_val = 2'd2;
        end
    end

    // Payload store: write-only port here, reads are registered in the FSM below.
    always_ff @(posedge clk) begin
        if (pay_wr) begin
            mem[wr_addr] <= in_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_HDR0;
            len       <= 8'd0;
            sum       <= 8'd0;
            wr_ptr    <= 8'd0;
            rd_ptr    <= 8'd0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_data  <= 8'd0;
            frame_len <= 8'd0;
            frame_ok  <= 1'b0;
            err_pulse <= 1'b0;
            err_code  <= 2'd0;
            err_cnt   <= 8'd0;
        end else begin
            frame_ok  <= 1'b0;
            err_pulse <= err_now;
            if (err_now) begin
                err_code <= err_val;
                if (err_cnt != 8'hFF) begin
                    err_cnt <= err_cnt + 8'd1;
                end
                state <= S_HDR0;
            end else begin
                case (state)
                    S_HDR0: begin
                        if (xfer && in_data == HEADER0) begin
                            state <= S_HDR1;
                        end
                    end
                    S_HDR1: begin
                        if (xfer) begin
                            if (in_data == HEADER1) begin
                                state <= S_LEN;
                            end else if (in_data != HEADER0) begin
                                state <= S_HDR0;
                            end
                        end
                    end
                    S_LEN: begin
                        if (xfer) begin
                            len    <= in_data;
                            sum    <= in_data;
                            wr_ptr <= 8'd0;
                            state  <= S_PAY;
                        end
                    end
                    S_PAY: begin
                        if (xfer) begin
                            sum <= sum + in_data;
                            if (wr_ptr == len_m1) begin
                                state <= S_CSUM;
                            end else begin
                                wr_ptr <= wr_ptr + 8'd1;
                            end
                        end
                    end
                    S_CSUM: begin
                        // Mismatch is handled by err_now; reaching here means the sum matched.
                        if (xfer) begin
                            state     <= S_OUT;
                            in_ready  <= 1'b0;
                            out_valid <= 1'b1;
                            frame_ok  <= 1'b1;
                            frame_len <= len;
                            rd_ptr    <= 8'd0;
                            out_data  <= mem[{AW{1'b0}}];
                            out_last  <= (len == 8'd1);
                        end
                    end
                    S_OUT: begin
                        if (out_take) begin
                            if (out_last) begin
                                state     <= S_HDR0;
                                in_ready  <= 1'b1;
                                out_valid <= 1'b0;
                                out_last  <= 1'b0;
                                rd_ptr    <= 8'd0;
                            end else begin
                                rd_ptr   <= rd_next;
                                out_data <= mem[rd_addr];
                                out_last <= (rd_next == len_m1);
                            end
                        end
                    end
                    default: begin
                        state <= S_HDR0;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_uart_frame_parser.sv
// Random and directed frame traffic for uart_frame_parser, checked against expectations
// derived from how each frame was built (payload, checksum, error kind).
module tb_uart_frame_parser;
    localparam int MAX_LEN = 32;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] in_data = 8'd0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic       frame_idle = 1'b0;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic       out_last;
    logic [7:0] frame_len;
    logic       frame_ok;
    logic       err_pulse;
    logic [1:0] err_code;
    logic [7:0] err_cnt;

    uart_frame_parser #(
        .HEADER0(8'h55),
        .HEADER1(8'hAA),
        .MAX_LEN(MAX_LEN)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .frame_idle(frame_idle),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_last  (out_last),
        .frame_len (frame_len),
        .frame_ok  (frame_ok),
        .err_pulse (err_pulse),
        .err_code  (err_code),
        .err_cnt   (err_cnt)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    typedef struct {
        logic [1:0] code;
        logic [7:0] cnt;
    } err_exp_t;

    err_exp_t   exp_err_q[$];
    int         exp_len_q[$];
    logic [7:0] exp_bytes_q[$];
    logic [7:0] pay_q[$];
    logic [7:0] seq_q[$];
    int         exp_err_cnt = 0;
    int         gap_max = 2;
    bit         hold_low = 1'b0;

    // Output-side scoreboard, sampled 2 time units after each rising edge.
    int         ok_seen = 0;
    int         err_seen = 0;
    int         cur_len = 0;
    int         cur_idx = 0;
    bit         active = 1'b0;
    bit         prev_stall = 1'b0;
    logic [7:0] prev_data = 8'd0;

    always begin
        @(posedge clk);
        #2;
        if (!rst_n) begin
            out_ready  = 1'b0;
            prev_stall = 1'b0;
            active     = 1'b0;
        end else begin
            check_eq("in_ready_vs_out_valid", 32'(in_ready), 32'(!out_valid));
            if (frame_ok) begin
                ok_seen++;
                if (exp_len_q.size() == 0) begin
                    check_eq("unexpected_frame_ok", 32'(frame_ok), 32'd0);
                end else begin
                    cur_len = exp_len_q.pop_front();
                    check_eq("frame_len", 32'(frame_len), 32'(cur_len));
                    cur_idx = 0;
                    active  = 1'b1;
                end
            end
            if (err_pulse) begin
                err_seen++;
                if (exp_err_q.size() == 0) begin
                    check_eq("unexpected_err_pulse", 32'(err_pulse), 32'd0);
                end else begin
                    err_exp_t e;
                    e = exp_err_q.pop_front();
                    check_eq("err_code", 32'(err_code), 32'(e.code));
                    check_eq("err_cnt", 32'(err_cnt), 32'(e.cnt));
                end
            end
            if (out_valid && !active) check_eq("unexpected_out_valid", 32'(out_valid), 32'd0);
            if (prev_stall) begin
                check_eq("stall_valid", 32'(out_valid), 32'd1);
                check_eq("stall_data", 32'(out_data), 32'(prev_data));
            end
            out_ready = hold_low ? 1'b0 : ($urandom_range(0, 3) != 0);
            if (out_valid && active && out_ready) begin
                logic [7:0] b;
                b = (exp_bytes_q.size() != 0) ? exp_bytes_q.pop_front() : 8'hxx;
                check_eq("out_data", 32'(out_data), 32'(b));
                check_eq("out_last", 32'(out_last), 32'(cur_idx == cur_len - 1));
                cur_idx++;
                if (cur_idx == cur_len) active = 1'b0;
            end
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
        end
    end

    task automatic send_byte(input logic [7:0] b, input logic idle);
        int guard = 0;
        repeat ($urandom_range(0, gap_max)) @(negedge clk);
        while (!in_ready && guard < 500) begin
            @(negedge clk);
            guard++;
        end
        if (!in_ready) check_eq("in_ready_wait", 32'(in_ready), 32'd1);
        in_data    = b;
        in_valid   = 1'b1;
        frame_idle = idle;
        @(negedge clk);
        in_valid   = 1'b0;
        frame_idle = 1'b0;
    endtask

    task automatic send_seq();
        foreach (seq_q[i]) send_byte(seq_q[i], 1'b0);
    endtask

    task automatic pulse_idle();
        frame_idle = 1'b1;
        @(negedge clk);
        frame_idle = 1'b0;
    endtask

    function automatic logic [7:0] csum_of();
        int s = pay_q.size();
        foreach (pay_q[i]) s += int'(pay_q[i]);
        return 8'(s % 256);
    endfunction

    task automatic random_payload(input int len);
        pay_q = {};
        for (int i = 0; i < len; i++) pay_q.push_back(8'($urandom_range(0, 255)));
    endtask

    task automatic frame_seq(input logic [7:0] cs);
        seq_q = {8'h55, 8'hAA, 8'(pay_q.size())};
        foreach (pay_q[i]) seq_q.push_back(pay_q[i]);
        seq_q.push_back(cs);
    endtask

    task automatic expect_ok();
        exp_len_q.push_back(pay_q.size());
        foreach (pay_q[i]) exp_bytes_q.push_back(pay_q[i]);
    endtask

    task automatic expect_err(input logic [1:0] code);
        err_exp_t e;
        if (exp_err_cnt < 255) exp_err_cnt++;
        e.code = code;
        e.cnt  = 8'(exp_err_cnt);
        exp_err_q.push_back(e);
    endtask

    task automatic wait_done();
        int guard = 0;
        while ((exp_len_q.size() != 0 || exp_err_q.size() != 0 || active) && guard < 3000) begin
            @(negedge clk);
            guard++;
        end
        check_eq("drain", 32'(exp_len_q.size() + exp_err_q.size() + int'(active)), 32'd0);
        repeat (2) @(negedge clk);
    endtask

    task automatic check_reset_outputs();
        check_eq("rst_in_ready", 32'(in_ready), 32'd1);
        check_eq("rst_out_valid", 32'(out_valid), 32'd0);
        check_eq("rst_out_last", 32'(out_last), 32'd0);
        check_eq("rst_out_data", 32'(out_data), 32'd0);
        check_eq("rst_frame_ok", 32'(frame_ok), 32'd0);
        check_eq("rst_err_pulse", 32'(err_pulse), 32'd0);
        check_eq("rst_err_code", 32'(err_code), 32'd0);
        check_eq("rst_frame_len", 32'(frame_len), 32'd0);
        check_eq("rst_err_cnt", 32'(err_cnt), 32'd0);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_reset_outputs();
        exp_err_cnt = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int ok0;
        int err0;
        repeat (2) @(negedge clk);
        check_reset_outputs();
        rst_n = 1'b1;
        @(negedge clk);

        // Nominal 3-byte frame
        ok0 = ok_seen;
        pay_q = {8'h11, 8'h22, 8'h33};
        seq_q = {8'h55, 8'hAA, 8'h03, 8'h11, 8'h22, 8'h33, 8'h69};
        expect_ok();
        send_seq();
        wait_done();
        check_eq("ok_count_basic", 32'(ok_seen - ok0), 32'd1);
        check_eq("frame_len_basic", 32'(frame_len), 32'd3);
        $display("txn basic: 55 AA 03 11 22 33 69");

        // Checksum error
        ok0 = ok_seen;
        seq_q = {8'h55, 8'hAA, 8'h02, 8'h01, 8'h02, 8'h00};
        expect_err(2'd2);
        send_seq();
        wait_done();
        check_eq("err_cnt_csum", 32'(err_cnt), 32'd1);
        check_eq("no_frame_csum", 32'(ok_seen - ok0), 32'd0);
        $display("txn bad checksum: 55 AA 02 01 02 00");

        // Reset mid-frame: no error reported
        err0 = err_seen;
        seq_q = {8'h55, 8'hAA, 8'h03, 8'h11};
        send_seq();
        apply_reset();
        repeat (3) @(negedge clk);
        check_eq("no_err_on_reset", 32'(err_seen - err0), 32'd0);
        $display("txn reset mid-frame");

        // Length errors
        seq_q = {8'h55, 8'hAA, 8'h00};
        expect_err(2'd1);
        send_seq();
        seq_q = {8'h55, 8'hAA, 8'h21};
        expect_err(2'd1);
        send_seq();
        wait_done();
        check_eq("err_cnt_len", 32'(err_cnt), 32'd2);
        $display("txn length errors: LEN=00 and LEN=21");

        // Resync on repeated HEADER0
        pay_q = {8'h7F};
        seq_q = {8'h55, 8'h55, 8'hAA, 8'h01, 8'h7F, 8'h80};
        expect_ok();
        send_seq();
        wait_done();
        $display("txn resync: 55 55 AA 01 7F 80");

        // Timeout then a good frame
        seq_q = {8'h55, 8'hAA, 8'h04, 8'h01, 8'h02};
        expect_err(2'd3);
        send_seq();
        pulse_idle();
        pay_q = {8'h10, 8'h20};
        frame_seq(csum_of());
        expect_ok();
        send_seq();
        wait_done();
        check_eq("err_code_timeout", 32'(err_code), 32'd3);
        $display("txn timeout then valid frame");

        // Downstream stall for 5 cycles
        hold_low = 1'b1;
        pay_q = {8'hA1, 8'hB2, 8'hC3};
        frame_seq(csum_of());
        expect_ok();
        send_seq();
        for (int i = 0; i < 5; i++) begin
            check_eq("stall_in_ready", 32'(in_ready), 32'd0);
            check_eq("stall_out_valid", 32'(out_valid), 32'd1);
            check_eq("stall_first_byte", 32'(out_data), 32'hA1);
            @(negedge clk);
        end
        hold_low = 1'b0;
        wait_done();
        $display("txn stalled output: 3-byte frame, out_ready low 5 cycles");

        // Randomized traffic
        for (int t = 0; t < 60; t++) begin
            int kind;
            int len;
            kind = $urandom_range(0, 4);
            len  = $urandom_range(1, MAX_LEN);
            case (kind)
                0: begin
                    random_payload(len);
                    frame_seq(csum_of());
                    expect_ok();
                    send_seq();
                    $display("txn %0d: valid frame len=%0d", t, len);
                end
                1: begin
                    random_payload(len);
                    frame_seq(csum_of() ^ 8'($urandom_range(1, 255)));
                    expect_err(2'd2);
                    send_seq();
                    $display("txn %0d: bad checksum len=%0d", t, len);
                end
                2: begin
                    logic [7:0] bad;
                    bad = ($urandom_range(0, 1) == 0) ? 8'd0 : 8'($urandom_range(MAX_LEN + 1, 255));
                    seq_q = {8'h55, 8'hAA, bad};
                    expect_err(2'd1);
                    send_seq();
                    $display("txn %0d: bad length %0d", t, bad);
                end
                3: begin
                    int pos;
                    pos = $urandom_range(0, 3);
                    random_payload(len);
                    seq_q = {8'h55};
                    if (pos >= 1) seq_q.push_back(8'hAA);
                    if (pos >= 2) seq_q.push_back(8'(len));
                    if (pos == 2) begin
                        int k;
                        k = $urandom_range(0, len - 1);
                        for (int i = 0; i < k; i++) seq_q.push_back(pay_q[i]);
                    end
                    if (pos == 3) foreach (pay_q[i]) seq_q.push_back(pay_q[i]);
                    expect_err(2'd3);
                    send_seq();
                    if ($urandom_range(0, 1) == 0) pulse_idle();
                    else send_byte(8'($urandom_range(0, 255)), 1'b1);
                    $display("txn %0d: timeout at stage %0d", t, pos);
                end
                default: begin
                    int n;
                    n = $urandom_range(1, 4);
                    for (int i = 0; i < n; i++) begin
                        logic [7:0] g;
                        g = 8'($urandom_range(0, 255));
                        if (g == 8'h55) g = 8'h56;
                        send_byte(g, 1'b0);
                    end
                    $display("txn %0d: %0d noise bytes", t, n);
                end
            endcase
        end
        wait_done();

        // Error counter saturation
        gap_max = 0;
        for (int i = 0; i < 256; i++) begin
            seq_q = {8'h55, 8'hAA, 8'h00};
            expect_err(2'd1);
            send_seq();
        end
        wait_done();
        check_eq("err_cnt_saturate", 32'(err_cnt), 32'd255);
        $display("txn saturation: 256 length errors");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
